// File: rtl/instr_mem_loader.sv
// instr_mem_loader: write side of the instruction memory; unpacks a framed byte stream
//   into little-endian 32-bit words, writes them to consecutive word addresses and keeps
//   the core held in reset until the whole image is in place.
// Latency: last payload byte accepted at edge N -> mem_wr during cycle N+1; release from N+2.
// Backpressure: in_ready drops only in the single WRITE cycle, in DONE and while RST is low.
// Ports:
//   CLK, RST (async active-low)      clock / reset
//   in_valid, in_data, in_ready      byte stream, transfer = in_valid & in_ready
//   mem_wr, mem_waddr, mem_wdata     instruction memory write port (one pulse per word)
//   cpu_hold, done, error            core hold, sticky load-complete, sticky frame error
//   word_cnt                         words written so far
// Optional build macro: LOADER_CHECKSUM_EN adds a trailing CSUM byte (mod-256 payload sum).
module instr_mem_loader #(
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter int          MAX_WORDS = 4096
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_wr,
  output logic [63:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [15:0] word_cnt
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_HDR, ST_LEN0, ST_LEN1, ST_DATA, ST_WRITE, ST_CHK, ST_DONE, ST_ERR
  } state_t;
  // After the payload the checksum byte is still owed.
  localparam state_t ST_END = ST_CHK;
`else
  typedef enum logic [2:0] {
    ST_HDR, ST_LEN0, ST_LEN1, ST_DATA, ST_WRITE, ST_DONE, ST_ERR
  } state_t;
  localparam state_t ST_END = ST_DONE;
`endif

  localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

  state_t      state_q, state_d;
  logic [15:0] len_q;
  logic [1:0]  lane_q;
  logic [23:0] asm_q;      // lanes 0..2 of the word being assembled
  logic        ready_st;
  logic        xfer;
  logic [16:0] len_in;     // full length as it completes in LEN1, one spare bit for the compare
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum_q;
`endif

  // Ready depends only on state; gated by RST so nothing is accepted while in reset.
  assign ready_st = (state_q != ST_WRITE) && (state_q != ST_DONE);
  assign in_ready = RST & ready_st;
  assign xfer     = in_valid & in_ready;
  assign len_in   = {1'b0, in_data, len_q[7:0]};

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_HDR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mem_wr   = 1'b0;
    cpu_hold = 1'b1;
    done     = 1'b0;
    error    = 1'b0;
    case (state_q)
      ST_HDR: begin
        if (xfer && in_data == 8'hA5) state_d = ST_LEN0;
      end
      ST_LEN0: begin
        if (xfer) state_d = ST_LEN1;
      end
      ST_LEN1: begin
        if (xfer) begin
          if (len_in > MAX_LEN)         state_d = ST_ERR;
          else if (len_in[15:0] == '0) state_d = ST_END;
          else                          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (xfer && lane_q == 2'd3) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        mem_wr  = 1'b1;
        // word_cnt still holds the index of the word being written this cycle.
        state_d = (word_cnt + 16'd1 == len_q) ? ST_END : ST_DATA;
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (xfer) state_d = (in_data == csum_q) ? ST_DONE : ST_ERR;
      end
`endif
      ST_DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
      end
      ST_ERR: begin
        error = 1'b1;
      end
      default: state_d = ST_HDR;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      len_q     <= '0;
      lane_q    <= '0;
      asm_q     <= '0;
      mem_waddr <= BASE_ADDR;
      mem_wdata <= '0;
      word_cnt  <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      if (xfer) begin
        case (state_q)
          ST_LEN0: len_q[7:0]  <= in_data;
          ST_LEN1: len_q[15:8] <= in_data;
          ST_DATA: begin
            case (lane_q)
              2'd0: asm_q[7:0]   <= in_data;
              2'd1: asm_q[15:8]  <= in_data;
              2'd2: asm_q[23:16] <= in_data;
              2'd3: begin
                // Write port registers load only here, so they hold between pulses.
                mem_wdata <= {in_data, asm_q};
                mem_waddr <= BASE_ADDR + {46'd0, word_cnt, 2'b00};
              end
            endcase
            lane_q <= lane_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            csum_q <= csum_q + in_data;
`endif
          end
          default: ;
        endcase
      end
      if (state_q == ST_WRITE) word_cnt <= word_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: framed streams, latency, error and reset cases.
module tb_instr_mem_loader;
  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        mem_wr;
  logic [63:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [15:0] word_cnt;

  int tests = 0;
  int fails = 0;

  logic [63:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          lo_cnt  = 0;   // cycles with in_ready low while loading
  int          lo_nowr = 0;   // of those, cycles without a write pulse
  logic [7:0]  frame[$];

  always #5 CLK = ~CLK;

  instr_mem_loader dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_wr    (mem_wr),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error),
    .word_cnt  (word_cnt)
  );

  always @(negedge CLK) begin
    if (RST && mem_wr) begin
      wr_addr.push_back(mem_waddr);
      wr_data.push_back(mem_wdata);
    end
    if (RST && !done && !in_ready) begin
      lo_cnt++;
      if (!mem_wr) lo_nowr++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send_byte(input logic [7:0] b, input bit rnd);
    int guard;
    int k;
    guard = 0;
    k = 0;
    if (rnd) begin
      while ($urandom_range(1, 0) == 1 && k < 6) begin
        in_valid = 1'b0;
        @(negedge CLK);
        k++;
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && guard < 50) begin
      @(negedge CLK);
      guard++;
    end
    check("accept_rdy", 64'(in_ready), 64'd1);
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic send_frame(input bit rnd);
    foreach (frame[i]) send_byte(frame[i], rnd);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    RST = 1'b0;
    #1;
    check("rst_in_ready",  64'(in_ready),  64'd0);
    check("rst_mem_wr",    64'(mem_wr),    64'd0);
    check("rst_mem_waddr", mem_waddr,      64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_cpu_hold",  64'(cpu_hold),  64'd1);
    check("rst_done",      64'(done),      64'd0);
    check("rst_error",     64'(error),     64'd0);
    check("rst_word_cnt",  64'(word_cnt),  64'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    wr_addr.delete();
    wr_data.delete();
    lo_cnt  = 0;
    lo_nowr = 0;
  endtask

  initial begin
    // ---- Test 1: two-word image, valid held high ----
    do_reset();
    check("hdr_ready", 64'(in_ready), 64'd1);
    frame = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    send_frame(0);
    check("t1_lat_wr",    64'(mem_wr),    64'd1);
    check("t1_lat_waddr", mem_waddr,      64'h4);
    check("t1_lat_wdata", 64'(mem_wdata), 64'h00100093);
    check("t1_lat_rdy",   64'(in_ready),  64'd0);
    check("t1_lat_cnt",   64'(word_cnt),  64'd1);
    check("t1_lat_done",  64'(done),      64'd0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'hB6, 0);
    in_valid = 1'b0;
`else
    @(negedge CLK);
`endif
    check("t1_done",      64'(done),      64'd1);
    check("t1_hold",      64'(cpu_hold),  64'd0);
    check("t1_error",     64'(error),     64'd0);
    check("t1_cnt",       64'(word_cnt),  64'd2);
    check("t1_wr_low",    64'(mem_wr),    64'd0);
    check("t1_done_rdy",  64'(in_ready),  64'd0);
    check("t1_hold_addr", mem_waddr,      64'h4);
    @(negedge CLK);
    check("t1_nwr",   64'(wr_addr.size()), 64'd2);
    check("t1_addr0", wr_addr[0],          64'h0);
    check("t1_data0", 64'(wr_data[0]),     64'h00000013);
    check("t1_addr1", wr_addr[1],          64'h4);
    check("t1_data1", 64'(wr_data[1]),     64'h00100093);

`ifdef LOADER_CHECKSUM_EN
    // ---- Test 2: bad checksum ----
    do_reset();
    frame = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h00};
    send_frame(0);
    @(negedge CLK);
    check("t2_error", 64'(error),           64'd1);
    check("t2_done",  64'(done),            64'd0);
    check("t2_hold",  64'(cpu_hold),        64'd1);
    check("t2_nwr",   64'(wr_addr.size()),  64'd2);
    send_byte(8'h55, 0);
    send_byte(8'hA5, 0);
    in_valid = 1'b0;
    @(negedge CLK);
    check("t2_err_sticky", 64'(error),          64'd1);
    check("t2_cnt",        64'(word_cnt),       64'd2);
    check("t2_nwr_after",  64'(wr_addr.size()), 64'd2);
`endif

    // ---- Test 3: junk before header, one word ----
    do_reset();
`ifdef LOADER_CHECKSUM_EN
    frame = '{8'hFF, 8'h00, 8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h38};
`else
    frame = '{8'hFF, 8'h00, 8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`endif
    send_frame(0);
    @(negedge CLK);
    @(negedge CLK);
    check("t3_done",  64'(done),            64'd1);
    check("t3_nwr",   64'(wr_addr.size()),  64'd1);
    check("t3_addr0", wr_addr[0],           64'h0);
    check("t3_data0", 64'(wr_data[0]),      64'hDEADBEEF);
    check("t3_cnt",   64'(word_cnt),        64'd1);

    // ---- Test 4: length 4097 exceeds the limit ----
    do_reset();
    frame = '{8'hA5, 8'h01, 8'h10};
    send_frame(0);
    check("t4_error", 64'(error),    64'd1);
    check("t4_hold",  64'(cpu_hold), 64'd1);
    check("t4_done",  64'(done),     64'd0);
    frame = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93};
    send_frame(0);
    @(negedge CLK);
    check("t4_nwr",   64'(wr_addr.size()), 64'd0);
    check("t4_cnt",   64'(word_cnt),       64'd0);
    check("t4_error_sticky", 64'(error),   64'd1);

    // ---- Test 5: test 1 frame with random valid gaps ----
    do_reset();
    frame = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    send_frame(1);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'hB6, 1);
    in_valid = 1'b0;
`endif
    repeat (3) @(negedge CLK);
    check("t5_done",  64'(done),            64'd1);
    check("t5_hold",  64'(cpu_hold),        64'd0);
    check("t5_error", 64'(error),           64'd0);
    check("t5_cnt",   64'(word_cnt),        64'd2);
    check("t5_nwr",   64'(wr_addr.size()),  64'd2);
    check("t5_addr1", wr_addr[1],           64'h4);
    check("t5_data0", 64'(wr_data[0]),      64'h00000013);
    check("t5_data1", 64'(wr_data[1]),      64'h00100093);
    check("t5_lo_cnt",  64'(lo_cnt),  64'd2);
    check("t5_lo_nowr", 64'(lo_nowr), 64'd0);

    // ---- Test 6: reset after 5 payload bytes, then resend ----
    do_reset();
    frame = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93};
    send_frame(0);
    check("t6_mid_cnt",   64'(word_cnt),  64'd1);
    check("t6_mid_wdata", 64'(mem_wdata), 64'h00000013);
    check("t6_mid_hold",  64'(cpu_hold),  64'd1);
    do_reset();
    frame = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
`ifdef LOADER_CHECKSUM_EN
    frame.push_back(8'hB6);
`endif
    send_frame(0);
    repeat (2) @(negedge CLK);
    check("t6_done",  64'(done),            64'd1);
    check("t6_cnt",   64'(word_cnt),        64'd2);
    check("t6_nwr",   64'(wr_addr.size()),  64'd2);
    check("t6_addr0", wr_addr[0],           64'h0);
    check("t6_addr1", wr_addr[1],           64'h4);

    // ---- Test 7: zero-length image ----
    do_reset();
`ifdef LOADER_CHECKSUM_EN
    frame = '{8'hA5, 8'h00, 8'h00, 8'h00};
`else
    frame = '{8'hA5, 8'h00, 8'h00};
`endif
    send_frame(0);
    check("t7_done", 64'(done),            64'd1);
    check("t7_hold", 64'(cpu_hold),        64'd0);
    @(negedge CLK);
    check("t7_nwr",  64'(wr_addr.size()),  64'd0);
    check("t7_cnt",  64'(word_cnt),        64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Program loader: the write side of the 32-bit instruction memory that the multicycle core only reads.
- Receives a framed byte stream (valid/ready) and assembles little-endian 32-bit words.
- Writes each word into the instruction memory write port at consecutive word addresses.
- Holds the core in reset until the whole image is written, then releases it.

Parameters:
BASE_ADDR, 64'h0, byte address of the first word written
MAX_WORDS, 4096, largest accepted word count; larger lengths are an error

Ports:
CLK  input  1  clock
RST  input  1  reset, asynchronous, active-low
in_valid  input  1  byte on in_data is valid
in_data  input  8  stream byte
in_ready  output  1  loader accepts the byte this cycle; a transfer is in_valid & in_ready at the rising edge
mem_wr  output  1  instruction memory write strobe, one-cycle pulse per word
mem_waddr  output  64  instruction memory write byte address
mem_wdata  output  32  instruction memory write data
cpu_hold  output  1  1 = keep core in reset
done  output  1  image loaded, core released (sticky)
error  output  1  frame error (sticky)
word_cnt  output  16  words written so far

Behaviour:
- Reset values (RST low, asynchronous):
  - state=HDR, mem_wr=0, mem_waddr=BASE_ADDR, mem_wdata=0, cpu_hold=1, done=0, error=0, word_cnt=0.
  - Byte-lane counter and checksum accumulator are also cleared.
  - in_ready=0 while RST is low.
- Frame format: 0xA5, LEN_LO, LEN_HI, LEN×4 payload bytes (word byte 0 first), then CSUM (only with the optional feature).
- States:
  - HDR: in_ready=1. Byte 0xA5 -> LEN0. Any other byte is discarded; stay in HDR.
  - LEN0: in_ready=1. Capture low length byte -> LEN1.
  - LEN1: in_ready=1. Capture high length byte.
    - LEN > MAX_WORDS -> ERR.
    - LEN == 0 -> CHK with the feature, DONE without it.
    - Otherwise -> DATA.
  - DATA: in_ready=1. Bytes fill lanes 0..3 as mem_wdata[7:0], [15:8], [23:16], [31:24]. Fourth byte accepted -> WRITE.
  - WRITE: exactly one cycle.
    - mem_wr=1, mem_waddr=BASE_ADDR+4*word_cnt (64-bit add, no wrap possible within MAX_WORDS), mem_wdata=assembled word, in_ready=0.
    - Next cycle: word_cnt+1 and mem_wr=0.
    - word_cnt+1 == LEN -> CHK with the feature, DONE without it; otherwise -> DATA.
  - CHK: in_ready=1. Accepted byte equal to the checksum -> DONE; else -> ERR.
  - DONE: in_ready=0, cpu_hold=0, done=1. Stays until reset.
  - ERR: in_ready=1; all bytes are drained and discarded. error=1, cpu_hold=1. Stays until reset.
- in_valid may drop at any time. No state advances without a transfer, except out of WRITE.
- mem_waddr and mem_wdata hold their last values when mem_wr=0.
- Reset mid-load: abandon the frame, return to HDR, and keep the core held. Memory contents already written are not cleared.
- Latency: last payload byte accepted at edge N -> mem_wr high during cycle N+1.
  - Without the feature: done=1 and cpu_hold=0 from cycle N+2.

Optional Feature:
LOADER_CHECKSUM_EN
- Defined: after the last payload word (or directly after LEN1 when LEN=0) one CSUM byte is expected.
  - CSUM must equal the 8-bit modulo-256 sum of all payload bytes.
  - A mismatch gives ERR: error=1, done=0, core stays held.
  - The CHK state and the 8-bit accumulator exist only in this build.
- Undefined: no CSUM byte is expected. DONE is entered right after the last WRITE (or after LEN1 when LEN=0). No accumulator logic.

Test Plan:
1. Stream A5 02 00 13 00 00 00 93 00 10 00 (+CSUM B6 if EN) with in_valid held high -> two write pulses: addr 0x0 data 0x00000013, then addr 0x4 data 0x00100093; word_cnt=2; done=1, cpu_hold=0, error=0.
2. LOADER_CHECKSUM_EN build, same frame but CSUM 0x00 -> both writes still occur, then error=1, done=0, cpu_hold=1; later bytes are accepted and ignored.
3. Stream FF 00 A5 01 00 EF BE AD DE (+CSUM 0x38) -> FF and 00 are discarded in HDR; one write at addr 0x0, data 0xDEADBEEF; done=1.
4. A5 01 10 (LEN=4097 > MAX_WORDS) -> error=1 after the third byte; no mem_wr ever; cpu_hold=1.
5. Test 1 frame with in_valid toggled randomly (50%) -> same addresses, data and final flags as test 1. in_ready=0 exactly on the two WRITE cycles.
6. RST pulled low after 5 payload bytes of test 1, then released and test 1 frame resent -> during reset all outputs return to reset values. After resend: word_cnt ends at 2, writes go to 0x0 and 0x4, done=1.
